// File: rtl/prog_rom.sv
// prog_rom: loadable instruction ROM with a registered, single-cycle fetch port.
// A host streams program words in LOAD state. Fetches are serviced only in IDLE.
// Fetches that are unloaded, out of range or misaligned return DEFAULT_WORD.
module prog_rom #(
  parameter int unsigned DEPTH        = 256,
  parameter logic [31:0] DEFAULT_WORD = 32'h0800_0000,
  parameter int unsigned AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic [31:0]   fetch_data,
  output logic          fetch_valid,
  output logic          fetch_err,
  input  logic          load_start,
  input  logic          load_we,
  input  logic [31:0]   load_data,
  input  logic          load_done,
  output logic          loading,
  output logic [AW:0]   load_count,
  output logic          load_ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   load_count_q, load_count_d;
  logic          load_ovf_q, load_ovf_d;
  logic [31:0]   fetch_data_q, fetch_data_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          fetch_err_q, fetch_err_d;

  logic [31:0]   mem_q [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;

  logic [AW-1:0] idx;
  logic          addr_bad;

  // Load FSM: restart beats write/done; a write in the done cycle lands before leaving LOAD
  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    load_ovf_d   = load_ovf_q;
    mem_we       = 1'b0;
    mem_waddr    = load_count_q[AW-1:0];
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d      = LOAD;
          load_count_d = '0;
          load_ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (load_start) begin
          load_count_d = '0;
          load_ovf_d   = 1'b0;
        end else begin
          if (load_we) begin
            if (load_count_q < FULL_CNT) begin
              mem_we       = 1'b1;
              load_count_d = load_count_q + 1'b1;
            end else begin
              load_ovf_d = 1'b1;
            end
          end
          if (load_done) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fetch response: uses the pre-update load count; holds data/err when no response
  always_comb begin
    idx           = fetch_addr[AW+1:2];
    addr_bad      = (fetch_addr[1:0] != 2'b00) || ((fetch_addr >> (AW + 2)) != '0);
    fetch_valid_d = fetch_req && (state_q == IDLE);
    fetch_data_d  = fetch_data_q;
    fetch_err_d   = fetch_err_q;
    if (fetch_valid_d) begin
      if (addr_bad) begin
        fetch_err_d  = 1'b1;
        fetch_data_d = DEFAULT_WORD;
      end else if ({1'b0, idx} < load_count_q) begin
        fetch_err_d  = 1'b0;
        fetch_data_d = mem_q[idx];
      end else begin
        fetch_err_d  = 1'b0;
        fetch_data_d = DEFAULT_WORD;
      end
    end
  end

  // Control and response registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      load_count_q  <= '0;
      load_ovf_q    <= 1'b0;
      fetch_data_q  <= DEFAULT_WORD;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_count_q  <= load_count_d;
      load_ovf_q    <= load_ovf_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  // Program storage: not reset, written only by accepted load words
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= load_data;
    end
  end

  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign loading     = (state_q == LOAD);
  assign load_count  = load_count_q;
  assign load_ovf    = load_ovf_q;

endmodule

// File: tb/tb_prog_rom.sv
// Directed bench for prog_rom: a DEPTH=256 and a DEPTH=4 instance share one stimulus stream.
module tb_prog_rom;

  localparam logic [31:0] DW = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        reset, fetch_req, load_start, load_we, load_done;
  logic [31:0] fetch_addr, load_data;

  logic [31:0] b_data, s_data;
  logic        b_valid, b_err, b_loading, b_ovf;
  logic        s_valid, s_err, s_loading, s_ovf;
  logic [8:0]  b_cnt;
  logic [2:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_rom u_big (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(b_data), .fetch_valid(b_valid), .fetch_err(b_err),
    .load_start(load_start), .load_we(load_we), .load_data(load_data), .load_done(load_done),
    .loading(b_loading), .load_count(b_cnt), .load_ovf(b_ovf)
  );

  prog_rom #(.DEPTH(4)) u_small (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_data(s_data), .fetch_valid(s_valid), .fetch_err(s_err),
    .load_start(load_start), .load_we(load_we), .load_data(load_data), .load_done(load_done),
    .loading(s_loading), .load_count(s_cnt), .load_ovf(s_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req  = 1'b0;
  endtask

  task automatic ld(input logic [31:0] w);
    load_we   = 1'b1;
    load_data = w;
    tick();
    load_we   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    load_start = 1'b0; load_we = 1'b0; load_done = 1'b0; load_data = '0;
    tick(); tick();
    // reset state
    chk("rst_valid", 32'(b_valid), 32'd0);
    chk("rst_err", 32'(b_err), 32'd0);
    chk("rst_data", b_data, DW);
    chk("rst_loading", 32'(b_loading), 32'd0);
    chk("rst_cnt", 32'(b_cnt), 32'd0);
    chk("rst_ovf", 32'(b_ovf), 32'd0);
    // reset beats a concurrent fetch
    fetch_req = 1'b1; tick(); fetch_req = 1'b0;
    chk("rst_prio_valid", 32'(b_valid), 32'd0);
    reset = 1'b0;

    // fetch of unloaded ROM
    fetch(32'h0);
    chk("f0_valid", 32'(b_valid), 32'd1);
    chk("f0_err", 32'(b_err), 32'd0);
    chk("f0_data", b_data, DW);

    // load_we / load_done in IDLE are ignored
    load_done = 1'b1; ld(32'hdead_beef); load_done = 1'b0;
    chk("idle_we_cnt", 32'(b_cnt), 32'd0);
    chk("idle_we_loading", 32'(b_loading), 32'd0);

    // three-word program
    load_start = 1'b1; tick(); load_start = 1'b0;
    chk("ld_loading", 32'(b_loading), 32'd1);
    ld(32'h2008_0040); ld(32'hac08_0000); ld(32'h3c17_4000);
    chk("ld_cnt3", 32'(b_cnt), 32'd3);
    load_done = 1'b1; tick(); load_done = 1'b0;
    chk("ld_done_loading", 32'(b_loading), 32'd0);
    fetch(32'h8);
    chk("f8_data", b_data, 32'h3c17_4000);
    chk("f8_err", 32'(b_err), 32'd0);
    chk("f8_cnt", 32'(b_cnt), 32'd3);
    chk("f8_small", s_data, 32'h3c17_4000);
    fetch(32'h4);
    chk("f4_data", b_data, 32'hac08_0000);
    // no request: valid drops, data/err hold
    tick();
    chk("hold_valid", 32'(b_valid), 32'd0);
    chk("hold_data", b_data, 32'hac08_0000);
    fetch(32'hC);
    chk("fC_data", b_data, DW);
    chk("fC_err", 32'(b_err), 32'd0);
    chk("fC_valid", 32'(b_valid), 32'd1);

    // misaligned and out of range
    fetch(32'h6);
    chk("f6_err", 32'(b_err), 32'd1);
    chk("f6_data", b_data, DW);
    chk("f6_valid", 32'(b_valid), 32'd1);
    fetch(32'h400);
    chk("f400_err", 32'(b_err), 32'd1);
    chk("f400_data", b_data, DW);
    fetch(32'h3FC);
    chk("f3FC_err", 32'(b_err), 32'd0);
    chk("f3FC_small_err", 32'(s_err), 32'd1);
    tick();
    chk("hold_err", 32'(s_err), 32'd1);

    // five-word load with fetch held (stall), last word with load_done
    load_start = 1'b1; tick(); load_start = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    ld(32'h1111_1111);
    chk("stall_valid1", 32'(b_valid), 32'd0);
    ld(32'h2222_2222);
    chk("stall_valid2", 32'(b_valid), 32'd0);
    ld(32'h3333_3333);
    ld(32'h4444_4444);
    chk("stall_valid4", 32'(b_valid), 32'd0);
    chk("stall_hold_data", b_data, DW);
    chk("small_cnt4", 32'(s_cnt), 32'd4);
    chk("small_ovf0", 32'(s_ovf), 32'd0);
    load_done = 1'b1; ld(32'h5555_5555); load_done = 1'b0;
    fetch_req = 1'b0;
    chk("done_we_valid", 32'(b_valid), 32'd0);
    chk("done_we_loading", 32'(b_loading), 32'd0);
    chk("big_cnt5", 32'(b_cnt), 32'd5);
    chk("big_ovf", 32'(b_ovf), 32'd0);
    chk("small_cnt_sat", 32'(s_cnt), 32'd4);
    chk("small_ovf1", 32'(s_ovf), 32'd1);
    chk("small_loading", 32'(s_loading), 32'd0);
    fetch(32'h10);
    chk("f10_big", b_data, 32'h5555_5555);
    chk("f10_small_err", 32'(s_err), 32'd1);
    chk("f10_small_data", s_data, DW);
    fetch(32'h0);
    chk("s0", s_data, 32'h1111_1111);
    fetch(32'hC);
    chk("sC", s_data, 32'h4444_4444);
    chk("bC", b_data, 32'h4444_4444);

    // restart has priority over write and done
    load_start = 1'b1; tick(); load_start = 1'b0;
    ld(32'haaaa_aaaa);
    chk("rs_cnt1", 32'(b_cnt), 32'd1);
    load_start = 1'b1; load_done = 1'b1; ld(32'hbbbb_bbbb);
    load_start = 1'b0; load_done = 1'b0;
    chk("rs_cnt0", 32'(b_cnt), 32'd0);
    chk("rs_loading", 32'(b_loading), 32'd1);
    chk("rs_small_ovf", 32'(s_ovf), 32'd0);

    // reset mid-load abandons the load
    ld(32'hcccc_cccc); ld(32'hdddd_dddd);
    chk("mid_cnt2", 32'(b_cnt), 32'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_cnt", 32'(b_cnt), 32'd0);
    chk("mid_rst_loading", 32'(b_loading), 32'd0);
    fetch(32'h0);
    chk("mid_rst_f0", b_data, DW);
    chk("mid_rst_f0_err", 32'(b_err), 32'd0);
    chk("mid_rst_f0_valid", 32'(b_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_rom.md
PROG_ROM -- requirements
Module: prog_rom

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit instruction words stored; power of two, 4 to 1024.
REQ-002 Parameter DEFAULT_WORD, default 32'h08000000: word returned for unloaded, out-of-range or misaligned fetches (jump to 0).
REQ-003 Parameter AW, default log2(DEPTH): word-index width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fetch_req  input  1  fetch request, sampled each cycle.
REQ-007 fetch_addr  input  32  byte address of requested instruction.
REQ-008 fetch_data  output  32  registered instruction word.
REQ-009 fetch_valid  output  1  fetch_data holds the response to the request of the previous cycle.
REQ-010 fetch_err  output  1  qualifies fetch_valid: request was misaligned or out of range.
REQ-011 load_start  input  1  enter load mode and clear the load pointer.
REQ-012 load_we  input  1  write load_data at the load pointer.
REQ-013 load_data  input  32  program word to store.
REQ-014 load_done  input  1  leave load mode.
REQ-015 loading  output  1  high while in LOAD state.
REQ-016 load_count  output  AW+1  number of words loaded since the last load_start.
REQ-017 load_ovf  output  1  sticky: a load_we arrived while load_count == DEPTH.

Function
REQ-018 The block SHALL implement FSM states IDLE and LOAD; loading = (state == LOAD).
REQ-019 In IDLE, load_start SHALL move to LOAD, clear load_count and load_ovf; load_we and load_done in IDLE SHALL be ignored.
REQ-020 In LOAD, load_we with load_count < DEPTH SHALL write mem[load_count] <= load_data and increment load_count.
REQ-021 In LOAD, load_we with load_count == DEPTH SHALL drop the word, hold load_count, and set load_ovf.
REQ-022 In LOAD, load_done SHALL return to IDLE; if load_we is high in the same cycle the write is performed first.
REQ-023 In LOAD, load_start SHALL restart: load_count <= 0, load_ovf <= 0, state stays LOAD; it takes priority over load_we and load_done in that cycle.
REQ-024 Fetch index SHALL be idx = fetch_addr[AW+1:2].
REQ-025 fetch_req high in IDLE SHALL produce fetch_valid = 1 on the next cycle (latency 1).
REQ-026 fetch_err SHALL be 1 if fetch_addr[1:0] != 0 or fetch_addr[31:AW+2] != 0; fetch_data SHALL then be DEFAULT_WORD.
REQ-027 Otherwise fetch_data SHALL be mem[idx] if idx < load_count, else DEFAULT_WORD, with fetch_err = 0.
REQ-028 load_count used in REQ-027 SHALL be the value before any same-cycle load update.
REQ-029 fetch_req in LOAD state (stall) SHALL give fetch_valid = 0 next cycle.
REQ-030 When fetch_valid = 0, fetch_data and fetch_err SHALL hold their previous values.
REQ-031 Memory contents SHALL NOT be modified by reset or by fetches; only by REQ-020.

Reset
REQ-032 On reset: state IDLE, loading 0, load_count 0, load_ovf 0, fetch_valid 0, fetch_err 0, fetch_data DEFAULT_WORD.
REQ-033 Reset mid-load SHALL abandon the load; afterwards all fetches SHALL return DEFAULT_WORD until a new load completes.
REQ-034 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-035 Reset, fetch addr 0x0 -> next cycle valid=1, err=0, data=32'h08000000.
REQ-036 load_start; load_we of 0x20080040, 0xac080000, 0x3c174000; load_done; fetch 0x8 -> data 0x3c174000, load_count 3; fetch 0xC -> DEFAULT_WORD, err 0.
REQ-037 Fetch 0x6 (misaligned) and 0x400 with DEPTH=256 -> valid=1, err=1, data DEFAULT_WORD.
REQ-038 DEPTH=4: five load_we -> load_count 4, load_ovf 1, mem[0..3] = first four words.
REQ-039 fetch_req held during LOAD -> fetch_valid 0 each cycle; load_done with load_we same cycle -> word stored, loading 0 next cycle.
REQ-040 Reset asserted after two load_we -> load_count 0, loading 0, fetch 0x0 returns DEFAULT_WORD.
